// File: rtl/cfg_word_loader.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : cfg_word_loader                                                 |
// | Purpose  : Write-side driver for the configuration latch bank. Accepts     |
// |            configuration words over a valid/ready handshake, drives each   |
// |            word on a shared data bus and pulses exactly one bit of a       |
// |            registered one-hot enable vector so that one latch slice        |
// |            captures it. Each word uses a SETUP / STROBE / HOLD sequence,   |
// |            which gives the level-sensitive latches 1 cycle of setup and    |
// |            at least 1 cycle of hold around a glitch-free enable.           |
// | Option   : CFG_LOADER_CHECKSUM_EN - after the last data word, one extra    |
// |            word is consumed and compared against the XOR of all data       |
// |            words. io_err reports a mismatch. When the macro is undefined   |
// |            io_err is tied low and no checksum register exists.             |
// | Ports    : clk            rising-edge clock                                |
// |            reset          asynchronous active-high reset                   |
// |            io_start       begin a load sequence (only in IDLE or DONE)     |
// |            io_in_valid    input word available                             |
// |            io_in_ready    loader accepts a word this cycle                 |
// |            io_in_bits     input configuration word                         |
// |            io_d_out       registered latch data bus                        |
// |            io_configs_en  registered one-hot latch enables                 |
// |            io_busy        load sequence in progress                        |
// |            io_done        all words written, held until next start         |
// |            io_err         checksum mismatch                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cfg_word_loader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 39,
  parameter int IDX_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WORD_W-1:0]    io_in_bits,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [NUM_WORDS-1:0] EN_ONE   = NUM_WORDS'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             start_load;
  logic             word_accept;
  logic             last_word;

  // Start is only honoured while not busy.
  assign start_load  = io_start && ((state == S_IDLE) || (state == S_DONE));
  assign word_accept = (state == S_WAIT) && io_in_valid;
  assign last_word   = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    io_in_ready = 1'b0;
    io_busy     = 1'b0;
    io_done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (io_start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        io_in_ready = 1'b1;
        io_busy     = 1'b1;
        if (io_in_valid) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        io_busy   = 1'b1;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        io_busy   = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        io_busy = 1'b1;
        if (last_word) begin
`ifdef CFG_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_CHECK: begin
        io_in_ready = 1'b1;
        io_busy     = 1'b1;
        if (io_in_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        io_done = 1'b1;
        if (io_start) state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data bus, word index and latch enables. The enables are a plain flop
  // bank loaded from SETUP so they can never glitch on a state decode, and
  // reset clears them asynchronously even in the middle of a strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      io_d_out      <= '0;
      io_configs_en <= '0;
    end else begin
      if (start_load) begin
        idx <= '0;
      end else if ((state == S_HOLD) && !last_word) begin
        idx <= idx + IDX_W'(1);
      end

      if (word_accept) begin
        io_d_out <= io_in_bits;
      end

      if (state == S_SETUP) begin
        io_configs_en <= EN_ONE << idx;
      end else begin
        io_configs_en <= '0;
      end
    end
  end

`ifdef CFG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
  logic              err_q;

  // The checksum word is only compared; it never reaches io_d_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_load) begin
        checksum <= '0;
        err_q    <= 1'b0;
      end else if (word_accept) begin
        checksum <= checksum ^ io_in_bits;
      end else if ((state == S_CHECK) && io_in_valid) begin
        err_q <= (io_in_bits != checksum);
      end
    end
  end

  assign io_err = err_q;
`else
  assign io_err = 1'b0;
`endif

endmodule
`default_nettype wire
